// File: rtl/calc_pkg.sv
// Shared constants for the calculate block: operator codes, error display code
// and the default displayable range (sign takes one of six digits).
// Optional modulo support is selected by the CALC_MOD_EN macro in calculate.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  localparam logic [31:0]        ERR_CODE    = 32'h00EE_0000;
  localparam logic signed [31:0] RES_MAX_DEF = 32'sd999999;
  localparam logic signed [31:0] RES_MIN_DEF = -32'sd99999;

endpackage

// File: rtl/calc_error_detect.sv
// Combinational error flag: operand range, result range, divide-by-zero, bad opcode.
// Latency: none (pure combinational).
// Backpressure: none; evaluated every cycle.
module calc_error_detect
  import calc_pkg::*;
#(
  parameter logic signed [31:0] RES_MAX = RES_MAX_DEF,
  parameter logic signed [31:0] RES_MIN = RES_MIN_DEF
) (
  input  logic signed [63:0] value,
  input  logic signed [31:0] op_a,
  input  logic signed [31:0] op_b,
  input  logic               div_zero,
  input  logic               op_bad,
  output logic               err
);

  localparam logic signed [63:0] MAX64 = 64'(RES_MAX);
  localparam logic signed [63:0] MIN64 = 64'(RES_MIN);

  logic signed [63:0] a64;
  logic signed [63:0] b64;
  assign a64 = 64'(op_a);
  assign b64 = 64'(op_b);

  // All error sources collapse into one flag; no priority between them is visible.
  always_comb begin
    err = div_zero || op_bad
       || (a64 > MAX64) || (a64 < MIN64)
       || (b64 > MAX64) || (b64 < MIN64)
       || (value > MAX64) || (value < MIN64);
  end

endmodule

// File: rtl/calculate.sv
// Registered signed calculator (add/sub/mul/div, modulo when CALC_MOD_EN is defined).
// Latency: exactly 1 sw_clk cycle; a new operation is accepted every cycle.
// Backpressure: none; out-of-range or illegal operations register ERR_CODE.
module calculate
  import calc_pkg::*;
#(
  parameter logic signed [31:0] RES_MAX  = RES_MAX_DEF,
  parameter logic signed [31:0] RES_MIN  = RES_MIN_DEF,
  parameter logic [31:0]        ERR_CODE = calc_pkg::ERR_CODE
) (
  input  logic        sw_clk,
  input  logic        rst,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  operator,
  output logic [31:0] result
);

  logic signed [31:0] a;
  logic signed [31:0] b;
  logic signed [31:0] safe_b;
  logic signed [32:0] sum33;
  logic signed [32:0] dif33;
  logic signed [63:0] prod64;
  logic signed [31:0] quot;
  logic signed [63:0] full;
  logic               div_zero;
  logic               op_bad;
  logic               err;

  assign a      = operand1;
  assign b      = operand2;
  // Divider never sees zero; the divide-by-zero case is flagged separately.
  assign safe_b = (b == 32'sd0) ? 32'sd1 : b;
  assign sum33  = 33'(a) + 33'(b);
  assign dif33  = 33'(a) - 33'(b);
  assign prod64 = 64'(a) * 64'(b);
  assign quot   = a / safe_b;

`ifdef CALC_MOD_EN
  logic signed [31:0] rem;
  assign rem = a % safe_b;
`endif

  // Select the full-precision value and the operator-specific error flags.
  always_comb begin
    full     = '0;
    div_zero = 1'b0;
    op_bad   = 1'b0;
    case (operator)
      OP_ADD: full = 64'(sum33);
      OP_SUB: full = 64'(dif33);
      OP_MUL: full = prod64;
      OP_DIV: begin
        full     = 64'(quot);
        div_zero = (b == 32'sd0);
      end
`ifdef CALC_MOD_EN
      OP_MOD: begin
        full     = 64'(rem);
        div_zero = (b == 32'sd0);
      end
`endif
      default: op_bad = 1'b1;
    endcase
  end

  calc_error_detect #(
    .RES_MAX (RES_MAX),
    .RES_MIN (RES_MIN)
  ) u_err (
    .value    (full),
    .op_a     (a),
    .op_b     (b),
    .div_zero (div_zero),
    .op_bad   (op_bad),
    .err      (err)
  );

  // Output register; reset clears the pending result immediately.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) result <= 32'd0;
    else      result <= err ? ERR_CODE : full[31:0];
  end

endmodule

// File: tb/tb_calculate.sv
// Self-checking bench for calculate: directed vectors, boundaries, reset, random vs model.
// Latency: expects each result one sw_clk after its inputs.
// Backpressure: none; inputs change every cycle.
module tb_calculate;

  localparam logic [31:0] ERR = 32'h00EE_0000;
  localparam longint      RMAX = 999999;
  localparam longint      RMIN = -99999;

`ifdef CALC_MOD_EN
  localparam bit MOD_EN = 1'b1;
`else
  localparam bit MOD_EN = 1'b0;
`endif

  logic        sw_clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [2:0]  operator = '0;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  calculate dut (
    .sw_clk   (sw_clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .operator (operator),
    .result   (result)
  );

  always #5 sw_clk = ~sw_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Reference: range rules applied to exact integer arithmetic.
  function automatic logic [31:0] model(input int a, input int b, input int op);
    longint la = a;
    longint lb = b;
    longint v  = 0;
    bit     e  = 0;
    if (la > RMAX || la < RMIN || lb > RMAX || lb < RMIN) e = 1;
    case (op)
      0: v = la + lb;
      1: v = la - lb;
      2: v = la * lb;
      3: if (lb == 0) e = 1; else v = la / lb;
      4: if (!MOD_EN || lb == 0) e = 1; else v = la % lb;
      default: e = 1;
    endcase
    if (v > RMAX || v < RMIN) e = 1;
    return e ? ERR : 32'(v);
  endfunction

  // Drive one operation, wait one edge, check against an explicit expectation.
  task automatic run(input string tag, input int a, input int b, input int op, input logic [31:0] exp);
    operand1 = a;
    operand2 = b;
    operator = 3'(op);
    @(posedge sw_clk);
    #1;
    chk(tag, result, exp);
  endtask

  int a_t [5] = '{10, -10, 100000, 7, 7};
  int b_t [5] = '{101, 101, -500, 0, 0};

  function automatic int rnd_operand();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 2000)) - 1000;
      1: return int'($urandom_range(0, 1099998)) - 99999;
      2: return int'($urandom);
      default: return ($urandom_range(0, 1) == 1) ? 999999 - int'($urandom_range(0, 2))
                                                  : -99999 + int'($urandom_range(0, 2));
    endcase
  endfunction

  initial begin
    logic [31:0] m4;
    #2;
    chk("reset_state", result, 32'd0);
    @(posedge sw_clk);
    #1;
    chk("reset_held", result, 32'd0);
    rst = 1'b1;

    // Directed vectors.
    m4 = MOD_EN ? 32'd10 : ERR;
    run("p10_add", 10, 101, 0, 32'd111);
    run("p10_sub", 10, 101, 1, -32'sd91);
    run("p10_mul", 10, 101, 2, 32'd1010);
    run("p10_div", 10, 101, 3, 32'd0);
    run("p10_mod", 10, 101, 4, m4);
    m4 = MOD_EN ? -32'sd10 : ERR;
    run("n10_add", -10, 101, 0, 32'd91);
    run("n10_sub", -10, 101, 1, -32'sd111);
    run("n10_mul", -10, 101, 2, -32'sd1010);
    run("n10_div", -10, 101, 3, 32'd0);
    run("n10_mod", -10, 101, 4, m4);
    m4 = MOD_EN ? 32'd0 : ERR;
    run("big_add", 100000, -500, 0, 32'd99500);
    run("big_sub", 100000, -500, 1, 32'd100500);
    run("big_mul", 100000, -500, 2, ERR);
    run("big_div", 100000, -500, 3, -32'sd200);
    run("big_mod", 100000, -500, 4, m4);
    run("div0",    7, 0, 3, ERR);
    run("mod0",    7, 0, 4, ERR);
    run("op5",     3, 4, 5, ERR);
    run("op6",     3, 4, 6, ERR);
    run("op7",     3, 4, 7, ERR);

    // Boundaries.
    run("max_ok",   999998, 1, 0, 32'd999999);
    run("max_over", 999999, 1, 0, ERR);
    run("min_ok",   -99998, 1, 1, -32'sd99999);
    run("min_over", -99999, 1, 1, ERR);
    run("opnd_big", 1000000, 0, 0, ERR);
    run("opnd_neg", 5, -100000, 1, ERR);

    // Asynchronous reset mid-stream.
    operand1 = 20; operand2 = 22; operator = 3'd0;
    @(posedge sw_clk);
    #1;
    chk("pre_rst", result, 32'd42);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", result, 32'd0);
    operand1 = 6; operand2 = 7; operator = 3'd2;
    @(posedge sw_clk);
    #1;
    chk("rst_hold_edge", result, 32'd0);
    #2;
    rst = 1'b1;
    @(posedge sw_clk);
    #1;
    chk("rst_release", result, 32'd42);

    // Randomized operations against the model.
    for (int i = 0; i < 300; i++) begin
      int a, b, op;
      a  = rnd_operand();
      b  = rnd_operand();
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) b = 0;
      run("rand", a, b, op, model(a, b, op));
    end

    // Directed table re-checked through the model, for every operator.
    for (int i = 0; i < 5; i++)
      for (int op = 0; op < 8; op++)
        run("table_model", a_t[i], b_t[i], op, model(a_t[i], b_t[i], op));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/calculate.md
CALCULATE -- requirements
Module: calculate

Interface
REQ-001 Parameter RES_MAX, default 999999: largest displayable result.
REQ-002 Parameter RES_MIN, default -99999: smallest displayable result (sign occupies one of six digits).
REQ-003 Parameter ERR_CODE, default 32'h00EE_0000: display code for "Error".
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 sw_clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 operand1  input  32  signed two's-complement left operand.
REQ-008 operand2  input  32  signed two's-complement right operand.
REQ-009 operator  input  3  operation code: 0 add, 1 subtract, 2 multiply, 3 divide, 4 modulo, 5-7 invalid.
REQ-010 result  output  32  registered signed result or ERR_CODE.

Function
REQ-011 Each rising sw_clk SHALL register the result of the current operand1/operand2/operator; latency exactly 1 cycle, no handshake, new operation accepted every cycle.
REQ-012 Add/subtract SHALL be computed at 33 bits, multiply at 64 bits, so no wrap-around reaches the range check.
REQ-013 Divide SHALL truncate toward zero; modulo remainder SHALL take the sign of operand1 (a = (a/b)*b + a%b).
REQ-014 Divide or modulo with operand2 == 0 SHALL yield ERR_CODE.
REQ-015 A full-precision result outside RES_MIN..RES_MAX SHALL yield ERR_CODE.
REQ-016 Either operand outside RES_MIN..RES_MAX SHALL yield ERR_CODE regardless of operator.
REQ-017 Operator codes 5-7 SHALL yield ERR_CODE.
REQ-018 A legal result SHALL be the 32-bit two's-complement value; ERR_CODE SHALL never be produced by a legal result, because it lies above RES_MAX.
REQ-019 Where several error conditions coincide, the output SHALL be the single ERR_CODE; no error priority is visible.

Reset
REQ-020 While rst is low, result SHALL be 32'd0 asynchronously.
REQ-021 Deassertion SHALL take effect on the next rising sw_clk; the first registered value is the operation present at that edge.
REQ-022 Reset asserted mid-stream SHALL discard the pending result; no other state exists.

Configuration
REQ-023 Macro CALC_MOD_EN SHALL control the modulo operation.
REQ-024 With CALC_MOD_EN defined, operator 4 SHALL compute modulo per REQ-013/REQ-014.
REQ-025 Without CALC_MOD_EN, no remainder logic SHALL be built and operator 4 SHALL yield ERR_CODE.

Structure
REQ-026 Package calc_pkg SHALL hold operator code constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD), ERR_CODE, and the default RES_MAX/RES_MIN.
REQ-027 Range and error checking SHALL live in one combinational sub-module, calc_error_detect, with inputs full-precision value, operands and flags, and outputs the error flag.
REQ-028 Arithmetic and the output register SHALL remain in calculate.

Verification
REQ-029 op1=10, op2=101, op=0/1/2/3/4 -> result 111, -91, 1010, 0, 10, each one cycle after the inputs are applied.
REQ-030 op1=-10, op2=101, op=0/1/2/3/4 -> 91, -111, -1010, 0, -10.
REQ-031 op1=100000, op2=-500, op=0/1/2/3/4 -> 99500, 100500, 32'h00EE_0000 (product -50000000 out of range), -200, 0.
REQ-032 op1=7, op2=0, op=3 and op=4 -> 32'h00EE_0000; op=5, 6 or 7 with any operands -> 32'h00EE_0000.
REQ-033 Boundaries: 999998+1 -> 999999; 999999+1 -> ERR_CODE; -99998-1 -> -99999; -99999-1 -> ERR_CODE; op1=1000000 with op=0 -> ERR_CODE.
REQ-034 Drive rst low mid-sequence -> result 0 immediately, without waiting for a clock edge; after release -> the correct value at the first edge. Repeat the suite without CALC_MOD_EN -> op=4 gives ERR_CODE.
